// File: rtl/sp256k_sram.sv
// Single-port 16K x 16 SPRAM model with nibble write mask, registered read,
// power gating and an optional array scrub after power-off.
module sp256k_sram #(
   parameter int unsigned ADDR_WIDTH       = 14,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned MASK_WIDTH       = DATA_WIDTH / 4,
   parameter bit          SCRUB_ON_POWERUP = 1'b1
) (
   input  logic                  CK,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] DI,
   input  logic [ADDR_WIDTH-1:0] AD,
   input  logic [MASK_WIDTH-1:0] MASKWE,
   input  logic                  WE,
   input  logic                  CS,
   input  logic                  STDBY,
   input  logic                  SLEEP,
   input  logic                  PWROFF_N,
   output logic [DATA_WIDTH-1:0] DO
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OFF   = 2'd1,
      S_CLEAR = 2'd2
   } scrub_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   scrub_state_t          state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] do_reg;
   logic                  access_en;
   logic                  do_load;
   logic [MASK_WIDTH-1:0] mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Scrub state and read-data register
   always_ff @(posedge CK or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         do_reg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (do_load) begin
            do_reg <= mem[AD];
         end
      end
   end

   // Next-state, array write port steering between user and scrubber
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      do_load   = 1'b0;
      mem_we    = '0;
      mem_addr  = AD;
      mem_wdata = DI;
      access_en = CS && !STDBY && !SLEEP && PWROFF_N && (state == S_IDLE);

      case (state)
         S_IDLE: begin
            if (SCRUB_ON_POWERUP && !PWROFF_N) begin
               state_nxt = S_OFF;
            end
            if (access_en) begin
               if (WE) begin
                  mem_we = MASKWE;
               end else begin
                  do_load = 1'b1;
               end
            end
         end
         S_OFF: begin
            if (PWROFF_N) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
            end
         end
         S_CLEAR: begin
            if (!PWROFF_N) begin
               state_nxt = S_OFF;
            end else begin
               mem_we    = '1;
               mem_addr  = cnt;
               mem_wdata = '0;
               if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state_nxt = S_IDLE;
               end else begin
                  cnt_nxt = cnt + ADDR_WIDTH'(1);
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Array: no reset, contents survive rst_n
   always_ff @(posedge CK) begin
      for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
         if (mem_we[i]) begin
            mem[mem_addr][4*i +: 4] <= mem_wdata[4*i +: 4];
         end
      end
   end

   // Output is blanked while asleep, powered off or scrubbing
   always_comb begin
      DO = do_reg;
      if (SLEEP || !PWROFF_N || (state != S_IDLE)) begin
         DO = '0;
      end
   end

endmodule

// File: tb/tb_sp256k_sram.sv
// Directed self-checking bench for sp256k_sram.
module tb_sp256k_sram;

   logic        CK;
   logic        rst_n;
   logic [15:0] DI;
   logic [13:0] AD;
   logic [3:0]  MASKWE;
   logic        WE;
   logic        CS;
   logic        STDBY;
   logic        SLEEP;
   logic        PWROFF_N;
   logic [15:0] DO;

   int n_checks = 0;
   int n_pass   = 0;

   sp256k_sram dut (
      .CK       (CK),
      .rst_n    (rst_n),
      .DI       (DI),
      .AD       (AD),
      .MASKWE   (MASKWE),
      .WE       (WE),
      .CS       (CS),
      .STDBY    (STDBY),
      .SLEEP    (SLEEP),
      .PWROFF_N (PWROFF_N),
      .DO       (DO)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic mem_write(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
      CS = 1'b1; WE = 1'b1; AD = a; DI = d; MASKWE = m;
      tick();
      CS = 1'b0; WE = 1'b0;
   endtask

   task automatic mem_read(input logic [13:0] a);
      CS = 1'b1; WE = 1'b0; AD = a;
      tick();
      CS = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; DI = '0; AD = '0; MASKWE = '0; WE = 1'b0; CS = 1'b0;
      STDBY = 1'b0; SLEEP = 1'b0; PWROFF_N = 1'b1;
      #12;
      check("reset_do", DO, 16'h0000);
      rst_n = 1'b1;

      // full write then read
      mem_write(14'h0123, 16'hBEEF, 4'hF);
      check("write_no_writethrough", DO, 16'h0000);
      CS = 1'b1; WE = 1'b0; AD = 14'h0123;
      #1;
      check("read_before_edge", DO, 16'h0000);
      tick();
      CS = 1'b0;
      check("full_read", DO, 16'hBEEF);

      // nibble masks
      mem_write(14'h0010, 16'h1234, 4'hF);
      mem_write(14'h0010, 16'hABAB, 4'b1100);
      mem_read(14'h0010);
      check("mask_upper", DO, 16'hAB34);
      mem_write(14'h0010, 16'hCDCD, 4'b0011);
      check("mask_write_hold_do", DO, 16'hAB34);
      mem_read(14'h0010);
      check("mask_lower", DO, 16'hABCD);
      mem_write(14'h0010, 16'h0000, 4'b0000);
      mem_read(14'h0010);
      check("mask_none", DO, 16'hABCD);

      // byte lane
      mem_write(14'h0007, 16'hFFFF, 4'hF);
      mem_write(14'h0007, {8'h5A, 8'h5A}, 4'b0011);
      mem_read(14'h0007);
      check("byte_lane", DO, 16'hFF5A);

      // chip select gating
      CS = 1'b0; WE = 1'b1; AD = 14'h0123; DI = 16'h0000; MASKWE = 4'hF;
      tick();
      WE = 1'b0;
      mem_read(14'h0123);
      check("cs_low_write_ignored", DO, 16'hBEEF);

      // standby holds DO
      STDBY = 1'b1;
      mem_read(14'h0010);
      check("stdby_hold", DO, 16'hBEEF);
      STDBY = 1'b0;

      // sleep forces DO low and blocks writes
      SLEEP = 1'b1;
      #1;
      check("sleep_do_zero", DO, 16'h0000);
      mem_write(14'h0123, 16'h0000, 4'hF);
      check("sleep_do_zero_edge", DO, 16'h0000);
      SLEEP = 1'b0;
      #1;
      check("sleep_release_hold", DO, 16'hBEEF);
      mem_read(14'h0123);
      check("sleep_write_ignored", DO, 16'hBEEF);

      // power-off scrub
      mem_write(14'h0000, 16'h1111, 4'hF);
      mem_write(14'h3FFF, 16'h1111, 4'hF);
      mem_read(14'h0000);
      check("pre_scrub_read", DO, 16'h1111);
      PWROFF_N = 1'b0;
      #1;
      check("pwroff_do_zero", DO, 16'h0000);
      repeat (3) tick();
      check("pwroff_do_zero_3cyc", DO, 16'h0000);
      PWROFF_N = 1'b1;
      tick();
      check("scrub_start_do_zero", DO, 16'h0000);
      repeat (100) tick();
      mem_read(14'h0000);
      mem_write(14'h0000, 16'h2222, 4'hF);
      repeat (16384 - 102 - 1) tick();
      check("scrub_busy", DO, 16'h0000);
      tick();
      check("scrub_done_hold", DO, 16'h1111);
      mem_read(14'h0000);
      check("scrub_addr0", DO, 16'h0000);
      mem_read(14'h3FFF);
      check("scrub_addr_top", DO, 16'h0000);
      mem_read(14'h0123);
      check("scrub_addr_mid", DO, 16'h0000);

      // asynchronous reset keeps memory
      mem_write(14'h0123, 16'hBEEF, 4'hF);
      mem_read(14'h0123);
      check("pre_reset_read", DO, 16'hBEEF);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_do", DO, 16'h0000);
      rst_n = 1'b1;
      mem_read(14'h0123);
      check("reset_mem_kept", DO, 16'hBEEF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sp256k_sram.md
Name: sp256k_sram

Overview:
Behavioural/synthesisable model of the iCE40UP single-port 256 Kbit SPRAM: 16384 x 16 words with nibble-granular write mask and synchronous registered read. It is the backing store for the CPU data RAM in SRAM mode. Byte-wide users duplicate the byte on DI and select a half via MASKWE. Power-control inputs (standby, sleep, power-off) gate access and output, and power-off triggers an array scrub.

Parameters:
ADDR_WIDTH, 14, word address bits (depth = 2**ADDR_WIDTH).
DATA_WIDTH, 16, word width; must be a multiple of 4.
MASK_WIDTH, DATA_WIDTH/4, number of nibble write-enable bits.
SCRUB_ON_POWERUP, 1, 1 = clear the whole array after PWROFF_N returns high; 0 = contents retained across power-off.

Ports:
CK  input  1  clock; all state changes occur on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
DI  input  DATA_WIDTH  write data.
AD  input  ADDR_WIDTH  word address.
MASKWE  input  MASK_WIDTH  nibble write enables; bit i high = write DI[4i+3:4i].
WE  input  1  1 = write cycle, 0 = read cycle.
CS  input  1  chip select; access only when high.
STDBY  input  1  standby: no access, contents kept, DO holds.
SLEEP  input  1  sleep: no access, contents kept, DO forced 0.
PWROFF_N  input  1  active-low power-off: no access, DO forced 0.
DO  output  DATA_WIDTH  registered read data.

Behaviour:
- One clock (CK); reset asynchronous, active-low (rst_n).
- Reset: DO register = 0; scrub FSM goes to IDLE; array contents untouched.
- Priority per edge: scrub active > !PWROFF_N > SLEEP > STDBY > !CS > access.
- Access enabled: CS=1, STDBY=0, SLEEP=0, PWROFF_N=1, scrub IDLE.
- Write (enabled, WE=1): for each i with MASKWE[i]=1, mem[AD] nibble i <= DI nibble i. Other nibbles are unchanged. MASKWE=0 gives a no-op write. DO holds its previous value (no write-through).
- Read (enabled, WE=0): DO_reg <= mem[AD]. Latency is 1 cycle, so data is visible after the rising edge. MASKWE is ignored.
- Back-to-back read of a just-written address returns the new data.
- Not enabled: array unchanged; DO_reg holds.
- DO output = 0 combinationally while SLEEP=1, PWROFF_N=0 or scrub active. Otherwise DO = DO_reg. After SLEEP deasserts, DO shows the held DO_reg value.
- Scrub FSM (SCRUB_ON_POWERUP=1), states IDLE, OFF, CLEAR.
  - IDLE->OFF when PWROFF_N=0 is sampled.
  - OFF->CLEAR when PWROFF_N=1 is sampled; the counter is loaded with 0.
  - CLEAR: write 0 to mem[cnt], cnt++, one word per cycle. On cnt = depth-1 the word is written and the FSM goes to IDLE. Clearing takes exactly 2**ADDR_WIDTH cycles.
  - PWROFF_N=0 during CLEAR -> OFF; the scrub restarts from 0 on the next power-up.
  - User accesses during OFF/CLEAR are ignored.
- SCRUB_ON_POWERUP=0: power-off only blocks access and forces DO=0; contents are retained.
- Address wrap: AD is exactly ADDR_WIDTH bits; no out-of-range case exists.
- X/undefined inputs are not required to be handled.

Test Plan:
- Full write then read: CS=1, WE=1, MASKWE=F, AD=0x0123, DI=0xBEEF; then WE=0 read of AD=0x0123 -> DO=0xBEEF one edge later; DO stayed at its old value during the write.
- Nibble mask: write 0x1234 (MASKWE=F), then DI=0xABAB with MASKWE=1100, then read -> 0xAB34. Next DI=0xCDCD with MASKWE=0011, then read -> 0xABCD.
- Byte lane usage: DI={8'h5A,8'h5A}, MASKWE=0011 at AD=7 over a word preloaded with 0xFFFF -> read 0xFF5A.
- Gating: CS=0 write of 0x0000 to AD=0x0123 is ignored (read -> 0xBEEF). STDBY=1 read holds DO. SLEEP=1 -> DO=0 immediately. SLEEP=0 -> previous DO reappears; no write occurred.
- Power-off scrub: write 0x1111 at AD=0 and at AD=0x3FFF. Drive PWROFF_N=0 for 3 cycles (DO=0), then 1. Wait 16384 cycles; reads at 0 and 0x3FFF return 0x0000. A read issued mid-scrub is ignored.
- Async reset: with DO=0xBEEF, pulse rst_n low between clock edges -> DO=0 immediately. Memory is kept: a following read of 0x0123 returns 0xBEEF.
